// File: rtl/bus_fifo.sv
// bus_fifo: parametrised single-clock FIFO between the master-group and
// slave-group sides of the system-bus bridges.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   data_in, enq   write data and enqueue request
//   deq            dequeue request
//   clr_err        synchronous clear of the sticky overflow/underflow flags
//   data_out       registered read data, held between dequeues
//   valid          one-cycle strobe: data_out holds a newly dequeued word
//   full, empty    count == DEPTH / count == 0
//   almost_full    count >= AF_THRESH
//   almost_empty   count <= AE_THRESH
//   count          current occupancy, 0..DEPTH
//   overflow       sticky: an enqueue was rejected
//   underflow      sticky: a dequeue was rejected
module bus_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       enq,
  input  logic                       deq,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count_nxt;
  logic             enq_ok;
  logic             deq_ok;

  // Acceptance uses the registered flags; a full FIFO can still take a
  // word when a dequeue frees a slot in the same cycle.
  always_comb begin
    deq_ok    = deq && !empty;
    enq_ok    = enq && (!full || deq_ok);
    count_nxt = count;
    case ({enq_ok, deq_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage is never reset; stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (enq_ok) mem[head] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      data_out     <= '0;
      valid        <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (enq_ok) head <= head + AW'(1);
      // When full with both accepted, head == tail: this read sees the old
      // word while the write above replaces it at the same edge.
      if (deq_ok) begin
        data_out <= mem[tail];
        tail     <= tail + AW'(1);
      end
      valid <= deq_ok;
      count <= count_nxt;

      // Flags come from the next-state count so they are exact next cycle.
      full         <= (count_nxt == CW'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(AF_THRESH));
      almost_empty <= (count_nxt <= CW'(AE_THRESH));

      // A new error in the same cycle as clr_err keeps the flag set.
      if (enq && !enq_ok)  overflow  <= 1'b1;
      else if (clr_err)    overflow  <= 1'b0;
      if (deq && !deq_ok)  underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_fifo.sv
// tb_bus_fifo: directed self-checking bench for bus_fifo at the default
// parameters (WIDTH=32, DEPTH=16, AF_THRESH=12, AE_THRESH=4).
module tb_bus_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        enq, deq, clr_err;
  logic [31:0] data_out;
  logic        valid, full, empty, almost_full, almost_empty;
  logic [4:0]  count;
  logic        overflow, underflow;

  int tests = 0;
  int fails = 0;

  bus_fifo #(.WIDTH(32), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .enq(enq), .deq(deq),
    .clr_err(clr_err), .data_out(data_out), .valid(valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock, then sample 1 time unit after the edge.
  task automatic cyc(input logic e, input logic d, input logic [31:0] di, input logic c);
    enq = e; deq = d; data_in = di; clr_err = c;
    @(posedge clk);
    #1;
    enq = 1'b0; deq = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},   32'(count), 0);
    chk({tag, "_empty"},   32'(empty), 1);
    chk({tag, "_full"},    32'(full), 0);
    chk({tag, "_af"},      32'(almost_full), 0);
    chk({tag, "_ae"},      32'(almost_empty), 1);
    chk({tag, "_valid"},   32'(valid), 0);
    chk({tag, "_dout"},    data_out, 0);
    chk({tag, "_ovf"},     32'(overflow), 0);
    chk({tag, "_unf"},     32'(underflow), 0);
  endtask

  initial begin
    rst = 1'b1; enq = 1'b0; deq = 1'b0; clr_err = 1'b0; data_in = '0;
    #2;
    chk_reset_state("rst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Fill 0x0..0xF
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 32'(i), 0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'(i + 1 >= 12));
      chk("fill_ae", 32'(almost_empty), 32'(i + 1 <= 4));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_empty", 32'(empty), 0);
    chk("fill_ovf0", 32'(overflow), 0);

    cyc(1, 0, 32'hDEAD, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 0);
      chk("drain_data", data_out, 32'(i));
      chk("drain_valid", 32'(valid), 1);
      chk("drain_count", 32'(count), 32'(15 - i));
    end
    chk("drain_empty", 32'(empty), 1);
    cyc(0, 0, 0, 0);
    chk("idle_valid", 32'(valid), 0);
    cyc(0, 1, 0, 0);
    chk("unf_set", 32'(underflow), 1);
    chk("unf_valid", 32'(valid), 0);
    chk("unf_hold", data_out, 32'hF);
    chk("ovf_sticky", 32'(overflow), 1);
    cyc(0, 0, 0, 1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_unf", 32'(underflow), 0);

    // Simultaneous enq+deq while empty: only the enqueue is accepted
    cyc(1, 1, 32'h55, 0);
    chk("se_unf", 32'(underflow), 1);
    chk("se_count", 32'(count), 1);
    chk("se_valid", 32'(valid), 0);
    chk("se_empty", 32'(empty), 0);
    cyc(0, 1, 0, 0);
    chk("se_data", data_out, 32'h55);
    chk("se_dvalid", 32'(valid), 1);
    chk("se_count0", 32'(count), 0);
    // clr_err together with a new underflow: set wins
    cyc(0, 1, 0, 1);
    chk("clr_vs_set", 32'(underflow), 1);
    cyc(0, 0, 0, 1);
    chk("clr_unf2", 32'(underflow), 0);

    // Simultaneous enq+deq while full, pointers wrap
    for (int i = 0; i < 16; i++) cyc(1, 0, 32'h100 + 32'(i), 0);
    chk("sf_full0", 32'(full), 1);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1, 32'h200 + 32'(k), 0);
      chk("sf_data", data_out, (k < 16) ? 32'h100 + 32'(k) : 32'h200 + 32'(k - 16));
      chk("sf_valid", 32'(valid), 1);
      chk("sf_count", 32'(count), 16);
      chk("sf_full", 32'(full), 1);
    end
    chk("sf_ovf", 32'(overflow), 0);
    chk("sf_unf", 32'(underflow), 0);
    for (int k = 4; k < 20; k++) begin
      cyc(0, 1, 0, 0);
      chk("sf_drain", data_out, 32'h200 + 32'(k));
    end
    chk("sf_empty", 32'(empty), 1);

    // Threshold edges
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 0, 32'h300 + 32'(i), 0);
      if (i == 4)  chk("th_ae4", 32'(almost_empty), 1);
      if (i == 5)  chk("th_ae5", 32'(almost_empty), 0);
      if (i == 11) chk("th_af11", 32'(almost_full), 0);
      if (i == 12) chk("th_af12", 32'(almost_full), 1);
    end
    cyc(0, 1, 0, 0);
    chk("th_af_fall", 32'(almost_full), 0);
    chk("th_count11", 32'(count), 11);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    chk("pre_rst_count", 32'(count), 7);
    chk("pre_rst_dout", data_out, 32'h305);

    // Asynchronous reset between edges
    #3;
    rst = 1'b1;
    #1;
    chk_reset_state("arst");
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    cyc(0, 1, 0, 0);
    chk("post_unf", 32'(underflow), 1);
    chk("post_valid", 32'(valid), 0);
    cyc(1, 0, 32'h33, 0);
    chk("post_count", 32'(count), 1);
    cyc(0, 1, 0, 0);
    chk("post_data", data_out, 32'h33);
    chk("post_dvalid", 32'(valid), 1);
    chk("post_empty", 32'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_fifo.md
Name: bus_fifo

Overview:
- Parametrised synchronous FIFO. Next-generation buffer between master-group and slave-group sides of the system-bus bridges.
- Adds the following over the first-generation FIFO:
  - legal simultaneous enqueue/dequeue, including when full or empty;
  - exact occupancy count output;
  - parameter-driven almost-full and almost-empty thresholds;
  - sticky overflow/underflow error flags with a clear input.
- Single clock domain. Registered read data with a one-cycle valid strobe.

Parameters:
- WIDTH, 32, data word width in bits (≥1).
- DEPTH, 16, number of entries. Power of two, ≥4.
- AF_THRESH, DEPTH-4, almost_full asserts when count ≥ AF_THRESH (1..DEPTH).
- AE_THRESH, 4, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  WIDTH  write data, sampled when the enqueue is accepted.
- enq  in  1  enqueue request.
- deq  in  1  dequeue request.
- clr_err  in  1  synchronous clear of overflow/underflow.
- data_out  out  WIDTH  read data, registered.
- valid  out  1  one-cycle strobe; data_out holds a newly dequeued word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: an enqueue was rejected.
- underflow  out  1  sticky: a dequeue was rejected.

Behaviour:
- Reset (rst high, asynchronous):
  - head, tail and count go to 0.
  - data_out=0, valid=0, full=0, empty=1, almost_full=(AF_THRESH==0 ? n/a : 0), almost_empty=1, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset mid-transfer discards all queued data. The first cycle after rst falls behaves as an empty FIFO.
- Acceptance, evaluated on registered flags at the clock edge:
  - deq_ok = deq && !empty.
  - enq_ok = enq && (!full || deq_ok). When full, enqueue is accepted only together with a dequeue.
  - Empty and enq && deq: only the enqueue is accepted; underflow sets.
- Write: on enq_ok, mem[head] <= data_in; head <= head+1, wrapping DEPTH-1 → 0.
- Read: on deq_ok, data_out <= mem[tail]; tail <= tail+1, wrapping DEPTH-1 → 0.
  - Next cycle valid=1; otherwise valid=0.
  - data_out holds its last value when no dequeue occurs.
  - When full with simultaneous enq_ok/deq_ok, head==tail: the read returns the old word, and the new word is written to the same slot.
- Latency:
  - A word enqueued in cycle N is dequeuable in cycle N+1, since empty deasserts at the N+1 edge.
  - data_out/valid appear at the edge after the accepted deq.
  - No fall-through.
- Count update: enq_ok only gives +1; deq_ok only gives −1; both or neither leaves it unchanged. Never exceeds DEPTH, never wraps below 0.
- Flags full/empty/almost_full/almost_empty: registered, computed from the next-state count, so they are exact in the cycle following the update.
- Error flags:
  - overflow sets when enq && !enq_ok.
  - underflow sets when deq && !deq_ok.
  - Both stay set until clr_err. If clr_err and a new error occur in the same cycle, set wins.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full/empty are derived from count, not from pointer comparison.

Test Plan:
- Reset then fill, DEPTH=16: 16 enqs of 0x0..0xF → count=16, full=1, almost_full=1 from count=12 onward, empty=0. 17th enq → overflow=1, count stays 16.
- Drain: 16 deqs → data_out 0x0..0xF in order, valid=1 one cycle after each deq, empty=1 after the last. Extra deq → underflow=1, valid=0, data_out holds 0xF.
- Simultaneous at full: enq 0xAA + deq for 20 cycles with pointers wrapping → count stays 16, full stays 1, outputs preserve FIFO order, no overflow.
- Simultaneous at empty: enq 0x55 + deq → enqueue accepted, underflow=1, count=1, valid=0. Next-cycle deq → data_out=0x55, valid=1.
- Threshold boundaries, AF_THRESH=12, AE_THRESH=4: count 4→5 drops almost_empty; 11→12 raises almost_full; 12→11 lowers it. clr_err with no new error clears both sticky flags.
- Async reset mid-stream at count=7, asserted between edges → all outputs reach reset values immediately. After release, a deq gives underflow=1, and an enq 0x33 then deq returns 0x33.
